// File: rtl/multicycle_control_fsm_pkg.sv
// Shared codes for the multi-cycle RV32I control path:
// opcodes, mux selects, ALU op classes and FSM states.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JAL,
    S_FAULT
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_R   = 3'b000;
  localparam logic [2:0] ALU_I   = 3'b001;
  localparam logic [2:0] ALU_LUI = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic is_mem_state(
    input state_e s
  );
    return (s == S_FETCH) || (s == S_MEM_RD) ||
           (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state
// and flags expiry on the last allowed stall cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_en_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam int unsigned CW =
    (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);
  localparam logic ENABLED = (MEM_WAIT_MAX != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;

  assign stall = count_en_i && !ready_i;
  // A ready in the limit cycle is not a stall, so it wins.
  assign expired_o = ENABLED && stall && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: drives datapath selects and
// enables, traps illegal ops and memory timeouts.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic             rs_equal_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic [1:0]       wb_sel_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             expired;
  ctrl_t            ctl;

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_d != state_q),
    .count_en_i(is_mem_state(state_q)),
    .ready_i   (mem_ready_i),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    ctl       = '0;
    unique case (state_q)
      S_FETCH: begin
        ctl.mem_read = 1'b1;
        ctl.src_a    = SRCA_PC;
        ctl.src_b    = SRCB_FOUR;
        ctl.alu_op   = ALU_ADD;
        if (mem_ready_i) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else if (expired) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        ctl.src_a  = SRCA_OLDPC;
        ctl.src_b  = SRCB_IMM;
        ctl.alu_op = ALU_ADD;
        unique case (opcode_i)
          OP_R, OP_I, OP_LUI: state_d = S_EXEC;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          default: begin
            state_d   = S_FAULT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        state_d = S_ALU_WB;
        unique case (opcode_i)
          OP_R: begin
            ctl.src_a  = SRCA_RS1;
            ctl.src_b  = SRCB_RS2;
            ctl.alu_op = ALU_R;
          end
          OP_I: begin
            ctl.src_a  = SRCA_RS1;
            ctl.src_b  = SRCB_IMM;
            ctl.alu_op = ALU_I;
          end
          OP_LUI: begin
            ctl.src_a  = SRCA_ZERO;
            ctl.src_b  = SRCB_IMM;
            ctl.alu_op = ALU_LUI;
          end
          default: begin
            state_d   = S_FAULT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_ALU_WB: begin
        ctl.reg_write = 1'b1;
        ctl.wb_sel    = WB_ALU;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctl.src_a  = SRCA_RS1;
        ctl.src_b  = SRCB_IMM;
        ctl.alu_op = ALU_ADD;
        state_d    = (opcode_i == OP_LOAD) ?
                     S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MEM_WB;
        end else if (expired) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end
      end
      S_MEM_WB: begin
        ctl.reg_write = 1'b1;
        ctl.wb_sel    = WB_MDR;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (expired) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end
      end
      S_BRANCH: begin
        ctl.pc_src = 1'b1;
        unique case (funct3_i)
          F3_BEQ: begin
            ctl.pc_write = rs_equal_i;
            retire       = 1'b1;
            state_d      = S_FETCH;
          end
          F3_BNE: begin
            ctl.pc_write = !rs_equal_i;
            retire       = 1'b1;
            state_d      = S_FETCH;
          end
          default: begin
            state_d   = S_FAULT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_JAL: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_src    = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.wb_sel    = WB_PC;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
    // Reset aborts the instruction in flight.
    if (reset) begin
      ctl = '0;
    end
    retired_d = retire ?
                retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  assign pc_write_o  = ctl.pc_write;
  assign pc_src_o    = ctl.pc_src;
  assign iord_o      = ctl.iord;
  assign mem_read_o  = ctl.mem_read;
  assign mem_write_o = ctl.mem_write;
  assign ir_write_o  = ctl.ir_write;
  assign reg_write_o = ctl.reg_write;
  assign wb_sel_o    = ctl.wb_sel;
  assign alu_src_a_o = ctl.src_a;
  assign alu_src_b_o = ctl.src_b;
  assign alu_op_o    = ctl.alu_op;
  assign illegal_o   = illegal_q;
  assign timeout_o   = timeout_q;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed plus random instruction streams checked cycle
// by cycle against an instruction-timeline model.
module tb_multicycle_control_fsm;

  localparam int MAXW = 4;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode_i = '0;
  logic [2:0]    funct3_i = '0;
  logic          rs_equal_i = 1'b0;
  logic          mem_ready_i = 1'b0;
  logic          pc_write_o, pc_src_o, iord_o;
  logic          mem_read_o, mem_write_o;
  logic          ir_write_o, reg_write_o;
  logic [1:0]    wb_sel_o, alu_src_a_o, alu_src_b_o;
  logic [2:0]    alu_op_o;
  logic          illegal_o, timeout_o;
  logic [CW-1:0] retired_o;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .MEM_WAIT_MAX(MAXW),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode_i   (opcode_i),
    .funct3_i   (funct3_i),
    .rs_equal_i (rs_equal_i),
    .mem_ready_i(mem_ready_i),
    .pc_write_o (pc_write_o),
    .pc_src_o   (pc_src_o),
    .iord_o     (iord_o),
    .mem_read_o (mem_read_o),
    .mem_write_o(mem_write_o),
    .ir_write_o (ir_write_o),
    .reg_write_o(reg_write_o),
    .wb_sel_o   (wb_sel_o),
    .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o),
    .alu_op_o   (alu_op_o),
    .illegal_o  (illegal_o),
    .timeout_o  (timeout_o),
    .retired_o  (retired_o)
  );

  typedef enum {
    K_R, K_I, K_LUI, K_LW, K_SW,
    K_BEQ, K_BNE, K_BX, K_JAL, K_ILL
  } kind_e;
  typedef enum {
    P_F, P_D, P_X, P_W, P_A, P_RD,
    P_LD, P_WR, P_B, P_J, P_Z, P_RST
  } ph_e;
  typedef enum {E_NONE, E_RET, E_ILL, E_TO} ev_e;

  int         total = 0;
  int         bad = 0;
  int         tail_n = 20;
  kind_e      cur_kind = K_R;
  logic [6:0] cur_op = '0;
  logic [6:0] ill_op = 7'h7F;
  logic [2:0] cur_f3 = '0;
  logic       cur_eq = 1'b0;
  int         exp_ret = 0;
  logic       exp_ill = 1'b0;
  logic       exp_to = 1'b0;

  function automatic logic [6:0] opc(input kind_e k);
    case (k)
      K_R:   return 7'b0110011;
      K_I:   return 7'b0010011;
      K_LUI: return 7'b0110111;
      K_LW:  return 7'b0000011;
      K_SW:  return 7'b0100011;
      K_JAL: return 7'b1101111;
      K_BEQ, K_BNE, K_BX: return 7'b1100011;
      default: return ill_op;
    endcase
  endfunction

  function automatic logic [6:0] rand_ill();
    logic [6:0] o;
    do o = 7'($urandom);
    while (o inside {7'b0110011, 7'b0010011,
                     7'b0110111, 7'b0000011,
                     7'b0100011, 7'b1100011,
                     7'b1101111});
    return o;
  endfunction

  // Expected controls for one cycle of a phase.
  function automatic logic [15:0] ectl(
    input ph_e ph, input logic rdy
  );
    logic pw, ps, io, mr, mw, iw, rw;
    logic [1:0] wb, a, b;
    logic [2:0] op;
    {pw, ps, io, mr, mw, iw, rw} = '0;
    wb = '0; a = '0; b = '0; op = '0;
    case (ph)
      P_F: begin
        mr = 1; b = 2'b01; op = 3'b011;
        pw = rdy; iw = rdy;
      end
      P_D: begin a = 2'b01; b = 2'b10; op = 3'b011; end
      P_X: begin
        case (cur_kind)
          K_R: a = 2'b10;
          K_I: begin a = 2'b10; b = 2'b10; op = 3'b001; end
          default: begin
            a = 2'b11; b = 2'b10; op = 3'b010;
          end
        endcase
      end
      P_W: rw = 1;
      P_A: begin a = 2'b10; b = 2'b10; op = 3'b011; end
      P_RD: begin mr = 1; io = 1; end
      P_LD: begin rw = 1; wb = 2'b01; end
      P_WR: begin mw = 1; io = 1; end
      P_B: begin
        ps = 1;
        pw = (cur_f3 == 3'd0) ? cur_eq :
             (cur_f3 == 3'd1) ? !cur_eq : 1'b0;
      end
      P_J: begin pw = 1; ps = 1; rw = 1; wb = 2'b10; end
      default: ;
    endcase
    return {pw, ps, io, mr, mw, iw, rw, wb, a, b, op};
  endfunction

  task automatic cyc(
    input ph_e ph, input logic rdy, input ev_e ev
  );
    logic [15:0] got, want;
    logic [5:0]  gs, ws;
    @(negedge clk);
    reset = (ph == P_RST);
    mem_ready_i = (ph inside {P_F, P_RD, P_WR, P_RST}) ?
                  rdy : 1'($urandom);
    if (ph == P_F || ph == P_RST) begin
      opcode_i   = 7'($urandom);
      funct3_i   = 3'($urandom);
      rs_equal_i = 1'($urandom);
    end else begin
      opcode_i   = cur_op;
      funct3_i   = cur_f3;
      rs_equal_i = (ph == P_B) ? cur_eq : 1'($urandom);
    end
    #1;
    got = {pc_write_o, pc_src_o, iord_o, mem_read_o,
           mem_write_o, ir_write_o, reg_write_o,
           wb_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o};
    want = ectl(ph, rdy);
    gs = {illegal_o, timeout_o, retired_o};
    ws = {exp_ill, exp_to, CW'(exp_ret)};
    total++;
    assert ({got, gs} === {want, ws}) else begin
      bad++;
      $error("FAIL %s ctl=%h st=%h exp ctl=%h st=%h",
             ph.name(), got, gs, want, ws);
    end
    case (ev)
      E_RET: exp_ret = (exp_ret + 1) % (1 << CW);
      E_ILL: exp_ill = 1'b1;
      E_TO:  exp_to = 1'b1;
      default: ;
    endcase
    if (ph == P_RST) begin
      exp_ret = 0; exp_ill = 1'b0; exp_to = 1'b0;
    end
  endtask

  task automatic chk(
    input string tag, input int got, input int want
  );
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  task automatic fault_tail();
    repeat (tail_n) cyc(P_Z, 1'b0, E_NONE);
    cyc(P_RST, 1'b0, E_NONE);
  endtask

  // st stall cycles, then ready; MAXW stalls trap instead.
  task automatic mem_phase(
    input ph_e ph, input int st, input ev_e ev,
    output bit ok
  );
    ok = (st < MAXW);
    for (int i = 0; i < st && i < MAXW; i++)
      cyc(ph, 1'b0, (i == MAXW - 1) ? E_TO : E_NONE);
    if (ok) cyc(ph, 1'b1, ev);
    else fault_tail();
  endtask

  task automatic run_instr(
    input kind_e k, input int fs, input int ms,
    input logic eq
  );
    bit ok;
    cur_kind = k;
    cur_eq   = eq;
    cur_op   = opc(k);
    case (k)
      K_BEQ:   cur_f3 = 3'd0;
      K_BNE:   cur_f3 = 3'd1;
      K_BX:    cur_f3 = 3'($urandom_range(7, 2));
      default: cur_f3 = 3'($urandom);
    endcase
    mem_phase(P_F, fs, E_NONE, ok);
    if (!ok) return;
    if (k == K_ILL) begin
      cyc(P_D, 1'b0, E_ILL);
      fault_tail();
      return;
    end
    cyc(P_D, 1'b0, E_NONE);
    case (k)
      K_R, K_I, K_LUI: begin
        cyc(P_X, 1'b0, E_NONE);
        cyc(P_W, 1'b0, E_RET);
      end
      K_LW: begin
        cyc(P_A, 1'b0, E_NONE);
        mem_phase(P_RD, ms, E_NONE, ok);
        if (ok) cyc(P_LD, 1'b0, E_RET);
      end
      K_SW: begin
        cyc(P_A, 1'b0, E_NONE);
        mem_phase(P_WR, ms, E_RET, ok);
      end
      K_BEQ, K_BNE: cyc(P_B, 1'b0, E_RET);
      K_BX: begin
        cyc(P_B, 1'b0, E_ILL);
        fault_tail();
      end
      default: cyc(P_J, 1'b0, E_RET);
    endcase
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cyc(P_RST, 1'b1, E_NONE);

    run_instr(K_R, 0, 0, 1'b0);
    run_instr(K_I, 0, 0, 1'b0);
    run_instr(K_LUI, 0, 0, 1'b0);
    @(posedge clk); #1;
    chk("retired_after_alu3", int'(retired_o), 3);

    run_instr(K_LW, 0, 3, 1'b0);
    run_instr(K_BEQ, 0, 0, 1'b1);
    run_instr(K_BNE, 0, 0, 1'b1);
    @(posedge clk); #1;
    chk("retired_after_br", int'(retired_o), 6);

    ill_op = 7'h7F;
    run_instr(K_ILL, 0, 0, 1'b0);
    run_instr(K_SW, 0, 4, 1'b0);
    run_instr(K_SW, 0, 3, 1'b0);
    run_instr(K_LW, 4, 0, 1'b0);
    run_instr(K_LW, 0, 4, 1'b0);
    run_instr(K_BX, 0, 0, 1'b0);

    cur_kind = K_SW;
    cur_op   = opc(K_SW);
    cyc(P_F, 1'b1, E_NONE);
    cyc(P_D, 1'b0, E_NONE);
    cyc(P_A, 1'b0, E_NONE);
    cyc(P_WR, 1'b0, E_NONE);
    cyc(P_RST, 1'b1, E_NONE);
    run_instr(K_JAL, 1, 0, 1'b0);

    repeat (15) run_instr(K_JAL, 0, 0, 1'b0);
    @(posedge clk); #1;
    chk("retired_wrap", int'(retired_o), 0);

    tail_n = 3;
    for (int n = 0; n < 250; n++) begin
      kind_e k;
      int fs, ms;
      k  = kind_e'($urandom_range(0, 9));
      fs = ($urandom_range(0, 15) == 0) ?
           4 : int'($urandom_range(0, 2));
      ms = ($urandom_range(0, 7) == 0) ?
           4 : int'($urandom_range(0, 3));
      ill_op = rand_ill();
      run_instr(k, fs, ms, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
